// File: rtl/id_ex_stage_pkg.sv
// Shared core definitions: ALU op codes, forwarding-select encodings, stage control word.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package id_ex_stage_pkg;

    // ALU operation codes carried from decode into execute
    localparam logic [3:0] ALU_ADD    = 4'b0000;
    localparam logic [3:0] ALU_SUB    = 4'b0001;
    localparam logic [3:0] ALU_AND    = 4'b0010;
    localparam logic [3:0] ALU_OR     = 4'b0011;
    localparam logic [3:0] ALU_XOR    = 4'b0100;
    localparam logic [3:0] ALU_SLT    = 4'b0101;
    localparam logic [3:0] ALU_SLTU   = 4'b0110;
    localparam logic [3:0] ALU_SLL    = 4'b0111;
    localparam logic [3:0] ALU_SRL    = 4'b1000;
    localparam logic [3:0] ALU_SRA    = 4'b1001;
    localparam logic [3:0] ALU_PASS_A = 4'b1111;

    // Operand source selected by the forwarding unit
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_W   = 2'b01;
    localparam logic [1:0] FWD_M   = 2'b10;

    // Control word held in the ID/EX register; all-zero is a bubble
    typedef struct packed {
        logic       valid;
        logic       regwrite;
        logic       memwrite;
        logic       memread;
        logic       branch;
        logic       jump;
        logic       alusrca;
        logic       alusrcb;
        logic [3:0] alu_control;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    // Memory stage is younger than writeback, so it wins when both match.
    // x0 is hardwired to zero and is never forwarded.
    function automatic logic [1:0] fwd_select(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic       regwrite_m,
        input logic [4:0] rd_w,
        input logic       regwrite_w
    );
        logic [1:0] sel;
        sel = FWD_REG;
        if (rs != 5'd0) begin
            if (regwrite_m && (rd_m == rs))
                sel = FWD_M;
            else if (regwrite_w && (rd_w == rs))
                sel = FWD_W;
        end
        return sel;
    endfunction

endpackage

// File: rtl/id_ex_stage_fwd_unit.sv
// Selects one execute operand from register file, memory-stage or writeback-stage result.
// Latency: purely combinational.
// Backpressure: none; follows whatever the stage register and later stages present.
module fwd_unit
    import id_ex_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [4:0]      rs,
    input  logic [XLEN-1:0] reg_val,
    input  logic [4:0]      rd_m,
    input  logic            regwrite_m,
    input  logic [XLEN-1:0] alu_result_m,
    input  logic [4:0]      rd_w,
    input  logic            regwrite_w,
    input  logic [XLEN-1:0] result_w,
    output logic [XLEN-1:0] fwd_val
);

    logic [1:0] sel;

    // Pick the freshest in-flight value for this source register
    always_comb begin
        sel     = fwd_select(rs, rd_m, regwrite_m, rd_w, regwrite_w);
        fwd_val = reg_val;
        case (sel)
            FWD_M:   fwd_val = alu_result_m;
            FWD_W:   fwd_val = result_w;
            default: fwd_val = reg_val;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding muxes and load-use hazard detect.
// Latency: 1 cycle D->E; operand/hazard outputs combinational from E regs. Macro EX_FORWARDING_EN enables forwarding.
// Backpressure: Stall_E holds every register; Flush_E (overrides stall) loads a bubble.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            Stall_E,
    input  logic            Flush_E,
    input  logic            Valid_D,
    input  logic            RegWrite_D,
    input  logic            MemWrite_D,
    input  logic            MemRead_D,
    input  logic            Branch_D,
    input  logic            Jump_D,
    input  logic            ALUSrcA_D,
    input  logic            ALUSrcB_D,
    input  logic [3:0]      ALU_Control_D,
    input  logic [XLEN-1:0] PC_D,
    input  logic [XLEN-1:0] RD1_D,
    input  logic [XLEN-1:0] RD2_D,
    input  logic [XLEN-1:0] ImmExt_D,
    input  logic [4:0]      Rs1_D,
    input  logic [4:0]      Rs2_D,
    input  logic [4:0]      Rd_D,
    input  logic [4:0]      Rd_M,
    input  logic            RegWrite_M,
    input  logic [XLEN-1:0] ALU_Result_M,
    input  logic [4:0]      Rd_W,
    input  logic            RegWrite_W,
    input  logic [XLEN-1:0] Result_W,
    output logic [XLEN-1:0] SrcA_E,
    output logic [XLEN-1:0] SrcB_E,
    output logic [XLEN-1:0] WriteData_E,
    output logic [3:0]      ALU_Control_E,
    output logic [XLEN-1:0] PC_E,
    output logic [XLEN-1:0] ImmExt_E,
    output logic [4:0]      Rd_E,
    output logic            Valid_E,
    output logic            RegWrite_E,
    output logic            MemWrite_E,
    output logic            MemRead_E,
    output logic            Branch_E,
    output logic            Jump_E,
    output logic            LoadUse_Hazard
);

    ctrl_t           ctrl_d;
    ctrl_t           ctrl_e;
    logic [4:0]      rd_e;
    logic [4:0]      rs1_e;
    logic [4:0]      rs2_e;
    logic [XLEN-1:0] pc_e;
    logic [XLEN-1:0] rd1_e;
    logic [XLEN-1:0] rd2_e;
    logic [XLEN-1:0] imm_e;
    logic [XLEN-1:0] fwd_a;
    logic [XLEN-1:0] fwd_b;

    // Gather decode controls into one word so bubble insertion is a single assignment
    always_comb begin
        ctrl_d             = CTRL_BUBBLE;
        ctrl_d.valid       = Valid_D;
        ctrl_d.regwrite    = RegWrite_D;
        ctrl_d.memwrite    = MemWrite_D;
        ctrl_d.memread     = MemRead_D;
        ctrl_d.branch      = Branch_D;
        ctrl_d.jump        = Jump_D;
        ctrl_d.alusrca     = ALUSrcA_D;
        ctrl_d.alusrcb     = ALUSrcB_D;
        ctrl_d.alu_control = ALU_Control_D;
    end

    // Control and destination index: flush beats stall, both lose to reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_e <= CTRL_BUBBLE;
            rd_e   <= '0;
        end else if (Flush_E) begin
            ctrl_e <= CTRL_BUBBLE;
            rd_e   <= '0;
        end else if (!Stall_E) begin
            ctrl_e <= ctrl_d;
            rd_e   <= Rd_D;
        end
    end

    // Datapath fields are meaningless in a bubble, so a flush simply loads them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_e  <= '0;
            rd1_e <= '0;
            rd2_e <= '0;
            imm_e <= '0;
            rs1_e <= '0;
            rs2_e <= '0;
        end else if (Flush_E || !Stall_E) begin
            pc_e  <= PC_D;
            rd1_e <= RD1_D;
            rd2_e <= RD2_D;
            imm_e <= ImmExt_D;
            rs1_e <= Rs1_D;
            rs2_e <= Rs2_D;
        end
    end

`ifdef EX_FORWARDING_EN
    fwd_unit #(.XLEN(XLEN)) u_fwd_rs1 (
        .rs           (rs1_e),
        .reg_val      (rd1_e),
        .rd_m         (Rd_M),
        .regwrite_m   (RegWrite_M),
        .alu_result_m (ALU_Result_M),
        .rd_w         (Rd_W),
        .regwrite_w   (RegWrite_W),
        .result_w     (Result_W),
        .fwd_val      (fwd_a)
    );

    fwd_unit #(.XLEN(XLEN)) u_fwd_rs2 (
        .rs           (rs2_e),
        .reg_val      (rd2_e),
        .rd_m         (Rd_M),
        .regwrite_m   (RegWrite_M),
        .alu_result_m (ALU_Result_M),
        .rd_w         (Rd_W),
        .regwrite_w   (RegWrite_W),
        .result_w     (Result_W),
        .fwd_val      (fwd_b)
    );
`else
    // Without forwarding the operands come straight from the register file read
    assign fwd_a = rd1_e;
    assign fwd_b = rd2_e;

    logic unused_fwd;
    assign unused_fwd = ^{Rd_M, RegWrite_M, ALU_Result_M, Rd_W, RegWrite_W, Result_W, rs1_e, rs2_e};
`endif

    // Operand muxes, store data and load-use detection against the instruction in decode
    always_comb begin
        SrcA_E         = ctrl_e.alusrca ? pc_e  : fwd_a;
        SrcB_E         = ctrl_e.alusrcb ? imm_e : fwd_b;
        WriteData_E    = fwd_b;
        LoadUse_Hazard = ctrl_e.valid && ctrl_e.memread && (rd_e != 5'd0) &&
                         ((rd_e == Rs1_D) || (rd_e == Rs2_D));
    end

    assign ALU_Control_E = ctrl_e.alu_control;
    assign PC_E          = pc_e;
    assign ImmExt_E      = imm_e;
    assign Rd_E          = rd_e;
    assign Valid_E       = ctrl_e.valid;
    assign RegWrite_E    = ctrl_e.regwrite;
    assign MemWrite_E    = ctrl_e.memwrite;
    assign MemRead_E     = ctrl_e.memread;
    assign Branch_E      = ctrl_e.branch;
    assign Jump_E        = ctrl_e.jump;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed table-driven bench for id_ex_stage plus stall/flush/reset sequences.
// Latency: expects one-cycle D->E capture, combinational operand outputs.
// Backpressure: exercises Stall_E hold and Flush_E bubble insertion.
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

`ifdef EX_FORWARDING_EN
    localparam bit F = 1'b1;
`else
    localparam bit F = 1'b0;
`endif

    logic        clk, rst, Stall_E, Flush_E;
    logic        Valid_D, RegWrite_D, MemWrite_D, MemRead_D, Branch_D, Jump_D, ALUSrcA_D, ALUSrcB_D;
    logic [3:0]  ALU_Control_D;
    logic [31:0] PC_D, RD1_D, RD2_D, ImmExt_D;
    logic [4:0]  Rs1_D, Rs2_D, Rd_D;
    logic [4:0]  Rd_M, Rd_W;
    logic        RegWrite_M, RegWrite_W;
    logic [31:0] ALU_Result_M, Result_W;
    logic [31:0] SrcA_E, SrcB_E, WriteData_E, PC_E, ImmExt_E;
    logic [3:0]  ALU_Control_E;
    logic [4:0]  Rd_E;
    logic        Valid_E, RegWrite_E, MemWrite_E, MemRead_E, Branch_E, Jump_E, LoadUse_Hazard;

    id_ex_stage #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .Stall_E(Stall_E), .Flush_E(Flush_E),
        .Valid_D(Valid_D), .RegWrite_D(RegWrite_D), .MemWrite_D(MemWrite_D), .MemRead_D(MemRead_D),
        .Branch_D(Branch_D), .Jump_D(Jump_D), .ALUSrcA_D(ALUSrcA_D), .ALUSrcB_D(ALUSrcB_D),
        .ALU_Control_D(ALU_Control_D), .PC_D(PC_D), .RD1_D(RD1_D), .RD2_D(RD2_D), .ImmExt_D(ImmExt_D),
        .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rd_D(Rd_D),
        .Rd_M(Rd_M), .RegWrite_M(RegWrite_M), .ALU_Result_M(ALU_Result_M),
        .Rd_W(Rd_W), .RegWrite_W(RegWrite_W), .Result_W(Result_W),
        .SrcA_E(SrcA_E), .SrcB_E(SrcB_E), .WriteData_E(WriteData_E), .ALU_Control_E(ALU_Control_E),
        .PC_E(PC_E), .ImmExt_E(ImmExt_E), .Rd_E(Rd_E), .Valid_E(Valid_E), .RegWrite_E(RegWrite_E),
        .MemWrite_E(MemWrite_E), .MemRead_E(MemRead_E), .Branch_E(Branch_E), .Jump_E(Jump_E),
        .LoadUse_Hazard(LoadUse_Hazard)
    );

    typedef struct {
        logic        valid, regwrite, memwrite, memread, branch, jump, srca, srcb;
        logic [3:0]  aluc;
        logic [31:0] pc, rd1, rd2, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [4:0]  rd_m, rd_w;
        logic        rw_m, rw_w;
        logic [31:0] res_m, res_w;
        logic [31:0] exp_a, exp_b, exp_wd;
        logic        exp_lu;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t vdef();
        vec_t v;
        v = '{default: '0};
        v.valid = 1'b1;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        Valid_D = v.valid; RegWrite_D = v.regwrite; MemWrite_D = v.memwrite; MemRead_D = v.memread;
        Branch_D = v.branch; Jump_D = v.jump; ALUSrcA_D = v.srca; ALUSrcB_D = v.srcb;
        ALU_Control_D = v.aluc; PC_D = v.pc; RD1_D = v.rd1; RD2_D = v.rd2; ImmExt_D = v.imm;
        Rs1_D = v.rs1; Rs2_D = v.rs2; Rd_D = v.rd;
        Rd_M = v.rd_m; RegWrite_M = v.rw_m; ALU_Result_M = v.res_m;
        Rd_W = v.rd_w; RegWrite_W = v.rw_w; Result_W = v.res_w;
    endtask

    function automatic logic [9:0] ctrl_out();
        return {Valid_E, RegWrite_E, MemWrite_E, MemRead_E, Branch_E, Jump_E, ALU_Control_E};
    endfunction

    function automatic logic [9:0] ctrl_exp(input vec_t v);
        return {v.valid, v.regwrite, v.memwrite, v.memread, v.branch, v.jump, v.aluc};
    endfunction

    task automatic check_vec(input vec_t v, input int idx);
        string t;
        t = $sformatf("v%0d", idx);
        check({t, ".ctrl"},  64'(ctrl_out()), 64'(ctrl_exp(v)));
        check({t, ".pc"},    64'(PC_E), 64'(v.pc));
        check({t, ".imm"},   64'(ImmExt_E), 64'(v.imm));
        check({t, ".rd"},    64'(Rd_E), 64'(v.rd));
        check({t, ".srca"},  64'(SrcA_E), 64'(v.exp_a));
        check({t, ".srcb"},  64'(SrcB_E), 64'(v.exp_b));
        check({t, ".wdata"}, 64'(WriteData_E), 64'(v.exp_wd));
        check({t, ".lu"},    64'(LoadUse_Hazard), 64'(v.exp_lu));
    endtask

    initial begin
        vec_t v, s;

        // 0: plain ADD, no forwarding sources active
        v = vdef(); v.regwrite = 1; v.aluc = ALU_ADD; v.pc = 32'h10; v.rs1 = 1; v.rs2 = 2; v.rd = 3;
        v.rd1 = 32'h10; v.rd2 = 32'h20; v.imm = 32'h5;
        v.exp_a = 32'h10; v.exp_b = 32'h20; v.exp_wd = 32'h20; tbl.push_back(v);
        // 1: x5 live in both M and W, M wins
        v = vdef(); v.aluc = ALU_SUB; v.rs1 = 5; v.rd1 = 32'h33; v.rs2 = 6; v.rd2 = 32'h44; v.rd = 1;
        v.rd_m = 5; v.rw_m = 1; v.res_m = 32'h11; v.rd_w = 5; v.rw_w = 1; v.res_w = 32'h22;
        v.exp_a = F ? 32'h11 : 32'h33; v.exp_b = 32'h44; v.exp_wd = 32'h44; tbl.push_back(v);
        // 2: rs2 from W only (M matches but not writing)
        v = vdef(); v.aluc = ALU_XOR; v.branch = 1; v.rs1 = 1; v.rd1 = 32'h1; v.rs2 = 9; v.rd2 = 32'h55;
        v.rd_m = 9; v.rw_m = 0; v.res_m = 32'hBAD; v.rd_w = 9; v.rw_w = 1; v.res_w = 32'h66;
        v.exp_a = 32'h1; v.exp_b = F ? 32'h66 : 32'h55; v.exp_wd = F ? 32'h66 : 32'h55; tbl.push_back(v);
        // 3: x0 is never forwarded
        v = vdef(); v.aluc = ALU_OR; v.rs1 = 0; v.rd1 = 32'h7; v.rs2 = 0; v.rd2 = 32'h0;
        v.rd_m = 0; v.rw_m = 1; v.res_m = 32'hFF; v.rd_w = 0; v.rw_w = 1; v.res_w = 32'hEE;
        v.exp_a = 32'h7; v.exp_b = 32'h0; v.exp_wd = 32'h0; tbl.push_back(v);
        // 4: PC and immediate operands, store data still forwarded
        v = vdef(); v.aluc = ALU_ADD; v.jump = 1; v.srca = 1; v.pc = 32'h80; v.srcb = 1; v.imm = 32'h4;
        v.rs1 = 2; v.rd1 = 32'h3; v.rs2 = 8; v.rd2 = 32'h99; v.rd_m = 8; v.rw_m = 1; v.res_m = 32'hAB;
        v.exp_a = 32'h80; v.exp_b = 32'h4; v.exp_wd = F ? 32'hAB : 32'h99; tbl.push_back(v);
        // 5: load to x7 while decode reads x7 on rs2
        v = vdef(); v.memread = 1; v.regwrite = 1; v.aluc = ALU_ADD; v.srcb = 1; v.imm = 32'h8;
        v.rs1 = 3; v.rd1 = 32'h100; v.rs2 = 7; v.rd2 = 32'h2; v.rd = 7;
        v.exp_a = 32'h100; v.exp_b = 32'h8; v.exp_wd = 32'h2; v.exp_lu = 1; tbl.push_back(v);
        // 6: load to x0 never hazards
        v = vdef(); v.memread = 1; v.aluc = ALU_SRA; v.rs1 = 0; v.rs2 = 0; v.rd = 0; v.rd1 = 32'h9; v.rd2 = 32'hA;
        v.exp_a = 32'h9; v.exp_b = 32'hA; v.exp_wd = 32'hA; tbl.push_back(v);
        // 7: invalid load does not hazard
        v = vdef(); v.valid = 0; v.memread = 1; v.aluc = ALU_PASS_A; v.rs1 = 7; v.rd = 7; v.rd1 = 32'hC; v.rd2 = 32'hD;
        v.exp_a = 32'hC; v.exp_b = 32'hD; v.exp_wd = 32'hD; tbl.push_back(v);
        // 8: rs1 match in M/W without RegWrite uses register value
        v = vdef(); v.memwrite = 1; v.aluc = ALU_SLL; v.rs1 = 4; v.rd1 = 32'h12; v.rs2 = 4; v.rd2 = 32'h34;
        v.rd_m = 4; v.res_m = 32'hDEAD; v.rd_w = 4; v.res_w = 32'hBEEF;
        v.exp_a = 32'h12; v.exp_b = 32'h34; v.exp_wd = 32'h34; tbl.push_back(v);

        // Reset state
        rst = 1'b1; Stall_E = 1'b0; Flush_E = 1'b0;
        drive(vdef());
        Valid_D = 1'b0;
        #12;
        check("rst.ctrl", 64'(ctrl_out()), 64'd0);
        check("rst.pc",   64'(PC_E), 64'd0);
        check("rst.rd",   64'(Rd_E), 64'd0);
        check("rst.srca", 64'(SrcA_E), 64'd0);
        rst = 1'b0;

        // Table vectors: one-cycle capture and combinational operands
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i]);
            @(posedge clk); #1;
            check_vec(tbl[i], i);
        end

        // Load-use then flush: bubble clears Valid and hazard
        drive(tbl[5]);
        @(posedge clk); #1;
        check("lu.pre", 64'(LoadUse_Hazard), 64'd1);
        Flush_E = 1'b1;
        @(posedge clk); #1;
        Flush_E = 1'b0;
        check("flush.valid", 64'(Valid_E), 64'd0);
        check("flush.lu",    64'(LoadUse_Hazard), 64'd0);
        check("flush.ctrl",  64'(ctrl_out()), 64'd0);
        check("flush.rd",    64'(Rd_E), 64'd0);

        // Stall holds everything for three cycles while decode changes
        s = vdef(); s.regwrite = 1; s.branch = 1; s.aluc = ALU_SLTU; s.pc = 32'h200; s.rd = 5'd10;
        s.rs1 = 11; s.rs2 = 12; s.rd1 = 32'hA1; s.rd2 = 32'hB2; s.imm = 32'hC3;
        drive(s);
        @(posedge clk); #1;
        Stall_E = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            v = vdef(); v.memwrite = 1; v.jump = 1; v.srca = 1; v.srcb = 1; v.aluc = ALU_SRL;
            v.pc = 32'h300 + 32'(k); v.rd = 5'(k); v.rd1 = 32'(k); v.rd2 = 32'(k + 1); v.imm = 32'(k + 2);
            drive(v);
            @(posedge clk); #1;
            check($sformatf("stall%0d.ctrl", k), 64'(ctrl_out()), 64'(ctrl_exp(s)));
            check($sformatf("stall%0d.pc", k),   64'(PC_E), 64'h200);
            check($sformatf("stall%0d.rd", k),   64'(Rd_E), 64'd10);
            check($sformatf("stall%0d.srca", k), 64'(SrcA_E), 64'hA1);
            check($sformatf("stall%0d.srcb", k), 64'(SrcB_E), 64'hB2);
            check($sformatf("stall%0d.imm", k),  64'(ImmExt_E), 64'hC3);
        end
        Flush_E = 1'b1;
        @(posedge clk); #1;
        check("stallflush.ctrl", 64'(ctrl_out()), 64'd0);
        check("stallflush.rd",   64'(Rd_E), 64'd0);
        Stall_E = 1'b0; Flush_E = 1'b0;

        // Asynchronous reset between edges, then resume capture
        v = vdef(); v.regwrite = 1; v.pc = 32'h100; v.rd = 5'd3; v.aluc = ALU_AND;
        v.rd1 = 32'h5; v.rd2 = 32'h6;
        drive(v);
        @(posedge clk); #1;
        check("pre_rst.rw", 64'(RegWrite_E), 64'd1);
        check("pre_rst.pc", 64'(PC_E), 64'h100);
        #2 rst = 1'b1;
        #1;
        check("arst.rw",    64'(RegWrite_E), 64'd0);
        check("arst.pc",    64'(PC_E), 64'd0);
        check("arst.valid", 64'(Valid_E), 64'd0);
        Stall_E = 1'b1; Flush_E = 1'b1;
        @(posedge clk); #1;
        check("rst_hold.ctrl", 64'(ctrl_out()), 64'd0);
        check("rst_hold.pc",   64'(PC_E), 64'd0);
        Stall_E = 1'b0; Flush_E = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        check("resume.ctrl", 64'(ctrl_out()), 64'(ctrl_exp(v)));
        check("resume.pc",   64'(PC_E), 64'h100);
        check("resume.srca", 64'(SrcA_E), 64'h5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have clk  input  1  rising-edge clock.
REQ-003 SHALL have rst  input  1  reset; one clock; asynchronous, active-high.
REQ-004 SHALL have Stall_E  input  1  hold all stage registers.
REQ-005 SHALL have Flush_E  input  1  load a bubble on next edge.
REQ-006 SHALL have Valid_D, RegWrite_D, MemWrite_D, MemRead_D, Branch_D, Jump_D  input  1 each  decode-stage controls.
REQ-007 SHALL have ALUSrcA_D  input  1  (0 = register, 1 = PC); ALUSrcB_D  input  1  (0 = register, 1 = immediate).
REQ-008 SHALL have ALU_Control_D  input  4  ALU op code.
REQ-009 SHALL have PC_D, RD1_D, RD2_D, ImmExt_D  input  XLEN each  decode operands.
REQ-010 SHALL have Rs1_D, Rs2_D, Rd_D  input  5 each  register indices.
REQ-011 SHALL have Rd_M  input  5; RegWrite_M  input  1; ALU_Result_M  input  XLEN  memory-stage forwarding source.
REQ-012 SHALL have Rd_W  input  5; RegWrite_W  input  1; Result_W  input  XLEN  writeback forwarding source.
REQ-013 SHALL have SrcA_E, SrcB_E, WriteData_E  output  XLEN  ALU operands and store data.
REQ-014 SHALL have ALU_Control_E  output  4; PC_E, ImmExt_E  output  XLEN; Rd_E  output  5; Valid_E, RegWrite_E, MemWrite_E, MemRead_E, Branch_E, Jump_E  output  1 each.
REQ-015 SHALL have LoadUse_Hazard  output  1  request decode stall.

Function
REQ-016 SHALL register all *_D inputs on each rising clk when Stall_E=0 and Flush_E=0; latency exactly one cycle.
REQ-017 SHALL hold every register unchanged when Stall_E=1 and Flush_E=0.
REQ-018 SHALL, when Flush_E=1 (overrides Stall_E), clear Valid_E, RegWrite_E, MemWrite_E, MemRead_E, Branch_E, Jump_E, Rd_E to 0 and ALU_Control_E to 4'b0000; datapath registers don't-care.
REQ-019 SHALL select forwarded rs1 value: ALU_Result_M if RegWrite_M & Rd_M!=0 & Rd_M==Rs1_E; else Result_W if RegWrite_W & Rd_W!=0 & Rd_W==Rs1_E; else registered RD1; memory stage wins when both match.
REQ-020 SHALL apply identical forwarding rules for rs2 against Rs2_E.
REQ-021 SHALL drive SrcA_E = PC_E if ALUSrcA_E else forwarded rs1; SrcB_E = ImmExt_E if ALUSrcB_E else forwarded rs2; WriteData_E = forwarded rs2 always; all combinational from registers and forwarding inputs.
REQ-022 SHALL never forward for index 0; x0 operands use registered RD values.
REQ-023 SHALL assert LoadUse_Hazard combinationally when Valid_E & MemRead_E & Rd_E!=0 & (Rd_E==Rs1_D | Rd_E==Rs2_D).
REQ-024 SHALL ignore forwarding inputs when Valid_E=0 only in the sense that outputs remain defined; Valid_E gates nothing else.

Reset
REQ-025 SHALL on rst=1 immediately clear all stage registers to 0 (control outputs 0, ALU_Control_E 4'b0000, PC_E 0); rst mid-stall or mid-flush wins over both.
REQ-026 SHALL resume normal capture on the first rising clk after rst deasserts.

Configuration
REQ-027 SHALL, with EX_FORWARDING_EN defined, implement REQ-019/020/022; without it, forwarded rs1/rs2 equal registered RD1/RD2, LoadUse_Hazard is still produced, and Rd_M/Rd_W/Result ports remain present but unused.

Structure
REQ-028 SHALL place ALU op-code constants (0000 ADD ... 1001 SRA, 1111 PASS-A) and forwarding-select encodings (00 reg, 01 W, 10 M) in the shared core package.
REQ-029 SHALL implement forwarding selection in one sub-module, fwd_unit, instantiated twice (rs1, rs2).

Verification
REQ-030 Add x5 written in M (Rd_M=5, RegWrite_M=1, ALU_Result_M=0x11), same x5 in W with Result_W=0x22, Rs1_E=5, RD1=0x33 -> SrcA_E=0x11.
REQ-031 Rd_M=0, RegWrite_M=1, ALU_Result_M=0xFF, Rs2_E=0, RD2=0 -> SrcB_E=0 and WriteData_E=0.
REQ-032 MemRead_E=1, Valid_E=1, Rd_E=7, Rs2_D=7 -> LoadUse_Hazard=1; with Flush_E pulsed, next cycle Valid_E=0, LoadUse_Hazard=0.
REQ-033 Stall_E=1 for 3 cycles with changing *_D -> all *_E outputs constant; Stall_E=1 & Flush_E=1 -> bubble loaded.
REQ-034 rst asserted between clock edges with RegWrite_E=1, PC_E=0x100 -> both 0 before next edge.
REQ-035 ALUSrcA_D=1, PC_D=0x80, ALUSrcB_D=1, ImmExt_D=0x4 -> next cycle SrcA_E=0x80, SrcB_E=0x4, WriteData_E=forwarded rs2.
